ads1292_frame_reader: RTL
=========================

Name: ads1292_frame_reader

Overview:
- Sits directly upstream of the 8-bit SPI master (CPOL=0, CPHA=1) on the ADS1292 path, and consumes that master's received bytes.
- On each falling edge of the ADC's DRDY line, asserts chip-select and clocks out 9 dummy bytes, which reads one 72-bit RDATAC frame (24-bit status, CH1, CH2).
- Assembles the frame and presents it with a one-cycle valid pulse to the downstream filter/packetiser.
- Owns CS timing, overrun and timeout detection.

Parameters:
- CS_SETUP_CYCLES, 8, i_CLK cycles between o_ADS_CSN falling and the first TX_DV.
- CS_HOLD_CYCLES, 8, i_CLK cycles between the last RX_DV and o_ADS_CSN rising.
- TIMEOUT_CYCLES, 1024, maximum i_CLK cycles allowed from a TX_DV to its RX_DV.

Ports:
- i_CLK  in  1  system clock (50 MHz)
- i_RSTN  in  1  synchronous active-low reset
- i_EN  in  1  enables frame capture; sampled only in IDLE
- i_ADS_DRDYN  in  1  ADC data-ready, active-low, asynchronous
- o_ADS_CSN  out  1  ADC chip-select, active-low
- o_SPI_TX_Byte  out  8  byte to SPI master; always 8'h00
- o_SPI_TX_DV  out  1  one-cycle transmit pulse to SPI master
- i_SPI_TX_Ready  in  1  SPI master idle/ready
- i_SPI_RX_DV  in  1  SPI master byte-received pulse
- i_SPI_RX_Byte  in  8  SPI master received byte
- o_STATUS  out  24  frame status word
- o_CH1  out  24  channel 1 sample, raw two's complement
- o_CH2  out  24  channel 2 sample, raw two's complement
- o_FRAME_VALID  out  1  one-cycle pulse when the outputs update
- o_OVERRUN  out  1  sticky: a DRDY fall arrived while busy; cleared by reset only
- o_TIMEOUT  out  1  one-cycle pulse when a frame is aborted on timeout
- o_BUSY  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: single clock i_CLK; i_RSTN is synchronous and active-low; all flops are reset only on posedge i_CLK with i_RSTN=0.
- Reset values:
  - o_ADS_CSN=1, o_SPI_TX_DV=0, o_SPI_TX_Byte=0.
  - o_STATUS, o_CH1, o_CH2 = 0.
  - o_FRAME_VALID=0, o_OVERRUN=0, o_TIMEOUT=0, o_BUSY=0.
  - FSM in IDLE; DRDY synchroniser flops = 1.
- DRDY handling: 2-flop synchroniser followed by a falling-edge detector (sync2 previous=1, current=0); this adds 3 cycles of latency.
- FSM states: IDLE, CS_SETUP, SEND, WAIT_RX, CS_HOLD, DONE.
- IDLE:
  - Goes to CS_SETUP on a DRDY fall with i_EN=1; drives o_ADS_CSN=0 on the transition.
  - Resets the byte index to 0.
  - A DRDY fall with i_EN=0 is ignored silently.
- CS_SETUP: counts CS_SETUP_CYCLES cycles, then goes to SEND.
- SEND:
  - Waits for i_SPI_TX_Ready=1.
  - Then drives o_SPI_TX_DV=1 for exactly one cycle, clears the timeout counter, and goes to WAIT_RX.
  - TX_DV is never asserted while Ready=0.
- WAIT_RX:
  - On i_SPI_RX_DV, stores i_SPI_RX_Byte into shift register bits [71:0], MSB first (byte 0 lands in [71:64]), and increments the index.
  - If index was 8, goes to CS_HOLD; otherwise goes to SEND.
  - If the counter reaches TIMEOUT_CYCLES first: pulse o_TIMEOUT, discard the partial frame, go to CS_HOLD, and do not pulse valid.
- CS_HOLD:
  - Counts CS_HOLD_CYCLES cycles, then sets o_ADS_CSN=1.
  - Then goes to DONE on a complete frame, or IDLE after a timeout.
- DONE:
  - Loads o_STATUS=[71:48], o_CH1=[47:24], o_CH2=[23:0] and pulses o_FRAME_VALID for 1 cycle in the same cycle.
  - Then goes to IDLE.
- Output hold: o_STATUS, o_CH1, o_CH2 hold their values until the next DONE.
- Overrun: a DRDY fall in any state other than IDLE sets o_OVERRUN and is not queued.
- i_EN deasserted mid-frame has no effect; the current frame completes.
- An RX_DV seen outside WAIT_RX is ignored.
- Reset mid-frame forces o_ADS_CSN=1 on the next edge and abandons the transfer.
- Counters: the byte index is 4 bits. The setup/hold/timeout counters are sized to ceil(log2(max parameter+1)) and saturate rather than wrap.

Optional Feature:
- Macro: ADS_FRAME_CHECK_EN.
- Defined:
  - In DONE, status bits [23:20] are checked against 4'b1100.
  - On a match, behaviour is as above.
  - On a mismatch, o_STATUS/o_CH1/o_CH2 are not updated, o_FRAME_VALID stays 0, and an added output o_FRAME_ERR (1 bit, reset 0) pulses for one cycle.
- Undefined: no check is made, the o_FRAME_ERR port does not exist, and every completed frame is reported valid.

Test Plan:
- Reset with i_EN=1, then a DRDY fall, with an SPI model returning C0_0000, 12_3456, FE_DCBA → o_STATUS=C00000, o_CH1=123456, o_CH2=FEDCBA, one o_FRAME_VALID pulse, exactly 9 TX_DV pulses, all bytes 8'h00.
- CS timing with defaults → ≥8 cycles from CSN fall to first TX_DV; ≥8 cycles from the 9th RX_DV to CSN rise; CSN low only while o_BUSY=1.
- Second DRDY fall during byte 4 → o_OVERRUN=1 and stays 1; current frame completes valid; no second frame starts.
- SPI model withholds RX_DV after byte 2 → o_TIMEOUT pulses after 1024 cycles; CSN returns high; no FRAME_VALID; outputs keep previous values.
- i_EN=0 with DRDY falling → CSN stays 1, no TX_DV; assert i_RSTN=0 during byte 5 → CSN=1, o_BUSY=0, outputs 0 on the next edge.
- With ADS_FRAME_CHECK_EN, status 0x80_0000 → o_FRAME_ERR pulse, no FRAME_VALID, outputs unchanged.

Source files
------------

// File: rtl/ads1292_frame_reader.sv
// ============================================================================
// ads1292_frame_reader
// ----------------------------------------------------------------------------
// Purpose:
//   Reads one 72-bit RDATAC frame (24-bit status, CH1, CH2) from an ADS1292
//   every time its DRDY line falls. The block owns the chip-select timing.
//   It issues nine dummy bytes to an 8-bit SPI master (CPOL=0, CPHA=1) and
//   assembles the received bytes MSB first. The finished frame goes to the
//   downstream filter/packetiser with a one-cycle valid pulse. The block also
//   flags DRDY overruns and aborts a transfer when the SPI master stops
//   answering.
//
// Optional feature (macro ADS_FRAME_CHECK_EN):
//   When the macro is defined, the status nibble [23:20] of each completed
//   frame is compared with 4'b1100. A frame that does not match is dropped:
//   the outputs keep their old values, no valid pulse is produced, and
//   o_FRAME_ERR pulses for one cycle. When the macro is undefined,
//   o_FRAME_ERR does not exist and every completed frame is reported valid.
//
// Parameters:
//   CS_SETUP_CYCLES  clocks from o_ADS_CSN falling to the first TX_DV
//   CS_HOLD_CYCLES   clocks from the last RX_DV to o_ADS_CSN rising
//   TIMEOUT_CYCLES   longest wait allowed from a TX_DV to its RX_DV
//
// Ports:
//   i_CLK           system clock (50 MHz)
//   i_RSTN          synchronous active-low reset
//   i_EN            frame capture enable, looked at only while idle
//   i_ADS_DRDYN     ADC data-ready, active-low, asynchronous to i_CLK
//   o_ADS_CSN       ADC chip-select, active-low
//   o_SPI_TX_Byte   byte to the SPI master (always 8'h00, dummy byte)
//   o_SPI_TX_DV     one-cycle transmit request to the SPI master
//   i_SPI_TX_Ready  SPI master is idle and can take a byte
//   i_SPI_RX_DV     SPI master received-byte strobe
//   i_SPI_RX_Byte   SPI master received byte
//   o_STATUS        status word of the last good frame
//   o_CH1           channel 1 sample of the last good frame (two's complement)
//   o_CH2           channel 2 sample of the last good frame (two's complement)
//   o_FRAME_VALID   one-cycle pulse when the three outputs update
//   o_OVERRUN       sticky: DRDY fell while a frame was in progress
//   o_TIMEOUT       one-cycle pulse when a frame is aborted on timeout
//   o_FRAME_ERR     (ADS_FRAME_CHECK_EN only) one-cycle bad-status pulse
//   o_BUSY          high whenever the reader is not idle
// ============================================================================
module ads1292_frame_reader #(
    parameter int CS_SETUP_CYCLES = 8,
    parameter int CS_HOLD_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic        i_CLK,
    input  logic        i_RSTN,
    input  logic        i_EN,
    input  logic        i_ADS_DRDYN,
    output logic        o_ADS_CSN,
    output logic [7:0]  o_SPI_TX_Byte,
    output logic        o_SPI_TX_DV,
    input  logic        i_SPI_TX_Ready,
    input  logic        i_SPI_RX_DV,
    input  logic [7:0]  i_SPI_RX_Byte,
    output logic [23:0] o_STATUS,
    output logic [23:0] o_CH1,
    output logic [23:0] o_CH2,
    output logic        o_FRAME_VALID,
    output logic        o_OVERRUN,
    output logic        o_TIMEOUT,
`ifdef ADS_FRAME_CHECK_EN
    output logic        o_FRAME_ERR,
`endif
    output logic        o_BUSY
);

    // One counter serves setup, hold and timeout. It is wide enough for the
    // largest of the three parameters and it saturates instead of wrapping.
    localparam int MAX_SH  = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
    localparam int MAX_CNT = (MAX_SH > TIMEOUT_CYCLES) ? MAX_SH : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(CS_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(CS_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SEND     = 3'd2,
        WAIT_RX  = 3'd3,
        CS_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cntInc;
    logic [3:0]        byteIdx_q, byteIdx_d;
    logic [71:0]       frame_q, frame_d;
    logic              aborted_q, aborted_d;
    logic              csn_q, csn_d;
    logic [23:0]       status_q, status_d;
    logic [23:0]       ch1_q, ch1_d;
    logic [23:0]       ch2_q, ch2_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic              txDv;
`ifdef ADS_FRAME_CHECK_EN
    logic              frameErr_q, frameErr_d;
`endif

    logic drdyMeta_q, drdySync_q, drdyPrev_q;
    logic drdyFall;

    // DRDY comes from the ADC clock domain. Two flops resynchronise it and a
    // third flop holds the previous value so a 1->0 step can be detected.
    // All three flops reset to 1, the idle level of DRDY, so a reset does not
    // create a false edge.
    always_ff @(posedge i_CLK) begin
        if (!i_RSTN) begin
            drdyMeta_q <= 1'b1;
            drdySync_q <= 1'b1;
            drdyPrev_q <= 1'b1;
        end else begin
            drdyMeta_q <= i_ADS_DRDYN;
            drdySync_q <= drdyMeta_q;
            drdyPrev_q <= drdySync_q;
        end
    end

    assign drdyFall = drdyPrev_q & ~drdySync_q;
    assign cntInc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    // Next-state logic for the frame sequencer and its datapath.
    // Every _d takes its held value first, and each state then overrides
    // only what it changes.
    // TX_DV is decoded directly from SEND and Ready. Because of this it can
    // never be high while the SPI master reports that it is busy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        byteIdx_d = byteIdx_q;
        frame_d   = frame_q;
        aborted_d = aborted_q;
        csn_d     = csn_q;
        status_d  = status_q;
        ch1_d     = ch1_q;
        ch2_d     = ch2_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        overrun_d = overrun_q | (drdyFall && (state_q != IDLE));
        txDv      = 1'b0;
`ifdef ADS_FRAME_CHECK_EN
        frameErr_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                byteIdx_d = 4'd0;
                cnt_d     = '0;
                aborted_d = 1'b0;
                if (drdyFall && i_EN) begin
                    csn_d   = 1'b0;
                    state_d = CS_SETUP;
                end
            end

            CS_SETUP: begin
                if (cnt_q >= SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = SEND;
                end else begin
                    cnt_d = cntInc;
                end
            end

            SEND: begin
                if (i_SPI_TX_Ready) begin
                    txDv    = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_RX;
                end
            end

            WAIT_RX: begin
                // A received byte takes priority over a timeout that expires
                // in the same cycle, so a late byte is still accepted.
                if (i_SPI_RX_DV) begin
                    frame_d   = {frame_q[63:0], i_SPI_RX_Byte};
                    byteIdx_d = byteIdx_q + 4'd1;
                    cnt_d     = '0;
                    state_d   = (byteIdx_q == 4'd8) ? CS_HOLD : SEND;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    timeout_d = 1'b1;
                    aborted_d = 1'b1;
                    frame_d   = '0;
                    cnt_d     = '0;
                    state_d   = CS_HOLD;
                end else begin
                    cnt_d = cntInc;
                end
            end

            CS_HOLD: begin
                if (cnt_q >= HOLD_LAST) begin
                    csn_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = aborted_q ? IDLE : DONE;
                end else begin
                    cnt_d = cntInc;
                end
            end

            DONE: begin
`ifdef ADS_FRAME_CHECK_EN
                if (frame_q[71:68] == 4'b1100) begin
                    status_d = frame_q[71:48];
                    ch1_d    = frame_q[47:24];
                    ch2_d    = frame_q[23:0];
                    valid_d  = 1'b1;
                end else begin
                    frameErr_d = 1'b1;
                end
`else
                status_d = frame_q[71:48];
                ch1_d    = frame_q[47:24];
                ch2_d    = frame_q[23:0];
                valid_d  = 1'b1;
`endif
                state_d = IDLE;
            end

            default: begin
                csn_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. A reset at any point abandons the
    // transfer and releases chip-select on the same edge.
    always_ff @(posedge i_CLK) begin
        if (!i_RSTN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            byteIdx_q  <= 4'd0;
            frame_q    <= '0;
            aborted_q  <= 1'b0;
            csn_q      <= 1'b1;
            status_q   <= '0;
            ch1_q      <= '0;
            ch2_q      <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef ADS_FRAME_CHECK_EN
            frameErr_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byteIdx_q  <= byteIdx_d;
            frame_q    <= frame_d;
            aborted_q  <= aborted_d;
            csn_q      <= csn_d;
            status_q   <= status_d;
            ch1_q      <= ch1_d;
            ch2_q      <= ch2_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
`ifdef ADS_FRAME_CHECK_EN
            frameErr_q <= frameErr_d;
`endif
        end
    end

    assign o_ADS_CSN     = csn_q;
    assign o_SPI_TX_Byte = 8'h00;
    assign o_SPI_TX_DV   = txDv;
    assign o_STATUS      = status_q;
    assign o_CH1         = ch1_q;
    assign o_CH2         = ch2_q;
    assign o_FRAME_VALID = valid_q;
    assign o_OVERRUN     = overrun_q;
    assign o_TIMEOUT     = timeout_q;
    assign o_BUSY        = (state_q != IDLE);
`ifdef ADS_FRAME_CHECK_EN
    assign o_FRAME_ERR   = frameErr_q;
`endif

endmodule
